// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; the controller drives the master side.
// With SERIAL_SUB_OVF_EN defined, the bundle also carries the signed-overflow flag V.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             B_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             V;

    modport master (output start, A, B, B_in, input busy, done, Diff, B_out, V);
    modport slave  (input start, A, B, B_in, output busy, done, Diff, B_out, V);
`else
    modport master (output start, A, B, B_in, input busy, done, Diff, B_out);
    modport slave  (input start, A, B, B_in, output busy, done, Diff, B_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - B_in, LSB first; SERIAL_SUB_OVF_EN adds the registered overflow flag V.
// Latency: done pulses WIDTH edges after the accepting edge; one operation per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE and is ignored while busy or done.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_a_i;
    logic             w_b_i;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_part_next;

    assign w_a_i       = r_a[0];
    assign w_b_i       = r_b[0];
    assign w_d         = w_a_i ^ w_b_i ^ r_br;
    assign w_br_next   = (~w_a_i & w_b_i) | (~(w_a_i ^ w_b_i) & r_br);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    // Each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign w_part_next = {w_d, r_part[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_v;
    logic w_v_next;

    assign w_v_next = (r_a_msb != r_b_msb) && (w_part_next[WIDTH-1] != r_a_msb);
    assign bus.V    = r_v;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_diff  <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_v     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_br    <= bus.B_in;
                        r_part  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= bus.A[WIDTH-1];
                        r_b_msb <= bus.B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_part <= w_part_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff  <= w_part_next;
                        r_bout  <= w_br_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        r_v     <= w_v_next;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.Diff  = r_diff;
    assign bus.B_out = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); define SERIAL_SUB_OVF_EN to also cover V.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Scoreboard entries: {V, B_out, Diff}
    logic [W+1:0] sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        int         s;
        logic       v;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        s = $signed({{28{a[W-1]}}, a}) - $signed({{28{b[W-1]}}, b}) - int'(bin);
        v = (s > 7) || (s < -8);
        return {v, r};
    endfunction

    function automatic logic [W+1:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    // Drive one request, push its expectation, and wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int done_edge, output int busy_cnt, output int hold_viol);
        logic [W-1:0] pd;
        logic         pb;
        @(negedge clk);
        pd = bus.Diff;
        pb = bus.B_out;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.B_in  = bin;
        sb.push_back(model(a, b, bin));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.B_in  = 1'($urandom);
        done_edge = -1;
        busy_cnt  = 0;
        hold_viol = 0;
        if (bus.busy) busy_cnt++;
        if (bus.Diff !== pd || bus.B_out !== pb) hold_viol++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.done) begin
                done_edge = n;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.Diff !== pd || bus.B_out !== pb) hold_viol++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.B_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.Diff !== 4'h0) begin n_fail++; $display("FAIL reset_diff: got %h want 0", bus.Diff); end
        n_checks++; if (bus.B_out !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b want 0", bus.B_out); end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++; if (bus.V !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", bus.V); end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        int de, bc, hv;
        logic [W+1:0] e;
        run_op(4'd9, 4'd3, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (de !== 4) begin n_fail++; $display("FAIL basic_done_edge: got %0d want 4", de); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL basic_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL basic_bout: got %b want %b", bus.B_out, e[W]); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", bus.busy); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
        n_checks++; if (bus.Diff !== 4'h6) begin n_fail++; $display("FAIL basic_diff_hold_idle: got %h want 6", bus.Diff); end
    endtask

    task automatic test_borrow();
        int de, bc, hv;
        logic [W+1:0] e;
        run_op(4'd3, 4'd9, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL borrow1_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL borrow1_bout: got %b want %b", bus.B_out, e[W]); end
        run_op(4'd0, 4'd0, 1'b1, de, bc, hv);
        e = sb_pop();
        n_checks++; if (de !== 4) begin n_fail++; $display("FAIL borrow2_done_edge: got %0d want 4", de); end
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL borrow2_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL borrow2_bout: got %b want %b", bus.B_out, e[W]); end
    endtask

    task automatic test_output_hold();
        int de, bc, hv;
        logic [W+1:0] e;
        run_op(4'd9, 4'd3, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL hold_first_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        run_op(4'd1, 4'd1, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL hold_during_run: got %0d changes want 0", hv); end
        n_checks++; if (de !== 4) begin n_fail++; $display("FAIL hold_done_edge: got %0d want 4", de); end
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL hold_second_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL hold_second_bout: got %b want %b", bus.B_out, e[W]); end
    endtask

    task automatic test_ignored_start();
        int first_done, second_done;
        logic [W+1:0] e;
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'd5;
        bus.B     = 4'd2;
        bus.B_in  = 1'b0;
        sb.push_back(model(4'd5, 4'd2, 1'b0));
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                bus.A = 4'hF;
                sb.push_back(model(4'hF, 4'd2, 1'b0));
            end
            if (k == 5) begin
                n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_start_in_done: busy got %b want 0", bus.busy); end
            end
            if (bus.done) begin
                e = sb_pop();
                if (first_done < 0) begin
                    first_done = k;
                    n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL ign_first_diff: got %h want %h", bus.Diff, e[W-1:0]); end
                end else begin
                    second_done = k;
                    bus.start = 1'b0;
                    n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL ign_second_diff: got %h want %h", bus.Diff, e[W-1:0]); end
                    break;
                end
            end
        end
        n_checks++; if (first_done !== 4) begin n_fail++; $display("FAIL ign_first_done_edge: got %0d want 4", first_done); end
        n_checks++; if (second_done !== 10) begin n_fail++; $display("FAIL ign_second_done_edge: got %0d want 10", second_done); end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_after: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_op();
        int de, bc, hv, done_seen;
        logic [W+1:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'd5;
        bus.B     = 4'd3;
        bus.B_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.Diff !== 4'h0) begin n_fail++; $display("FAIL midrst_diff: got %h want 0", bus.Diff); end
        n_checks++; if (bus.B_out !== 1'b0) begin n_fail++; $display("FAIL midrst_bout: got %b want 0", bus.B_out); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
        run_op(4'd7, 4'd7, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (de !== 4) begin n_fail++; $display("FAIL midrst_after_done_edge: got %0d want 4", de); end
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL midrst_after_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL midrst_after_bout: got %b want %b", bus.B_out, e[W]); end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_overflow();
        int de, bc, hv;
        logic [W+1:0] e;
        run_op(4'd8, 4'd1, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL ovf1_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.V !== e[W+1]) begin n_fail++; $display("FAIL ovf1_v: got %b want %b", bus.V, e[W+1]); end
        n_checks++; if (bus.B_out !== e[W]) begin n_fail++; $display("FAIL ovf1_bout: got %b want %b", bus.B_out, e[W]); end
        run_op(4'd4, 4'd2, 1'b0, de, bc, hv);
        e = sb_pop();
        n_checks++; if (bus.Diff !== e[W-1:0]) begin n_fail++; $display("FAIL ovf2_diff: got %h want %h", bus.Diff, e[W-1:0]); end
        n_checks++; if (bus.V !== e[W+1]) begin n_fail++; $display("FAIL ovf2_v: got %b want %b", bus.V, e[W+1]); end
        run_op(4'd7, 4'd8, 1'b1, de, bc, hv);
        e = sb_pop();
        n_checks++; if (bus.V !== e[W+1]) begin n_fail++; $display("FAIL ovf3_v: got %b want %b", bus.V, e[W+1]); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_output_hold();
        test_ignored_start();
        test_reset_mid_op();
`ifdef SERIAL_SUB_OVF_EN
        test_overflow();
`endif
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
